// File: rtl/pc_seq_ctrl.sv
// Multicycle next-PC sequencer: IDLE -> DECODE -> RESOLVE -> UPDATE, one instruction per 4 cycles.
// Latency: accept in cycle N, done/new pc visible in N+3. Optional macro PC_ALIGN_CHECK_EN flags misaligned jr/jalr targets.
module pc_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        ready,
    output logic [31:0] pc,
    output logic [31:0] imm_ext,
    output logic        br_taken,
    output logic        link_we,
    output logic [31:0] link_addr,
    output logic        done,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_RESOLVE,
        S_UPDATE
    } state_t;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;

    state_t      state_q;
    logic [31:0] instr_q;
    logic [31:0] pc_plus4_q;
    logic [31:0] rs_q;
    logic [31:0] rt_q;
    logic [31:0] pc_q;
    logic [31:0] imm_q;
    logic [31:0] link_addr_q;
    logic        ready_q;
    logic        br_taken_q;
    logic        link_we_q;
    logic        done_q;

    logic [31:0] imm_d;
    logic        taken_d;
    logic [31:0] target_d;
    logic        link_d;
    logic        reg_jump_d;
    logic        err_d;

    // Immediate extension is decided from the live instruction so it is ready in DECODE.
    always_comb begin
        imm_d = {{16{instr[15]}}, instr[15:0]};
        case (instr[31:26])
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: imm_d = {16'h0000, instr[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  rt_f;
        logic [31:0] br_off;
        opcode     = instr_q[31:26];
        funct      = instr_q[5:0];
        rt_f       = instr_q[20:16];
        br_off     = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        taken_d    = 1'b0;
        target_d   = pc_plus4_q;
        link_d     = 1'b0;
        reg_jump_d = 1'b0;
        case (opcode)
            OP_BEQ: begin
                taken_d  = (rs_q == rt_q);
                target_d = pc_plus4_q + br_off;
            end
            OP_BNE: begin
                taken_d  = (rs_q != rt_q);
                target_d = pc_plus4_q + br_off;
            end
            OP_REGIMM: begin
                if (rt_f == RT_BGEZ) begin
                    taken_d  = ~rs_q[31];
                    target_d = pc_plus4_q + br_off;
                end
            end
            OP_J, OP_JAL: begin
                taken_d  = 1'b1;
                target_d = {pc_plus4_q[31:28], instr_q[25:0], 2'b00};
                link_d   = (opcode == OP_JAL);
            end
            OP_SPECIAL: begin
                if (funct == FN_JR || funct == FN_JALR) begin
                    taken_d    = 1'b1;
                    target_d   = rs_q;
                    reg_jump_d = 1'b1;
                    link_d     = (funct == FN_JALR);
                end
            end
            default: ;
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    logic addr_err_q;
    assign err_d    = reg_jump_d && (target_d[1:0] != 2'b00);
    assign addr_err = addr_err_q;
`else
    assign err_d    = 1'b0;
    assign addr_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            instr_q     <= 32'h0;
            pc_plus4_q  <= 32'h0;
            rs_q        <= 32'h0;
            rt_q        <= 32'h0;
            pc_q        <= RESET_PC;
            imm_q       <= 32'h0;
            link_addr_q <= 32'h0;
            ready_q     <= 1'b1;
            br_taken_q  <= 1'b0;
            link_we_q   <= 1'b0;
            done_q      <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            addr_err_q  <= 1'b0;
`endif
        end else begin
            br_taken_q <= 1'b0;
            link_we_q  <= 1'b0;
            done_q     <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            addr_err_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (instr_valid) begin
                        instr_q    <= instr;
                        pc_plus4_q <= pc_q + 32'd4;
                        imm_q      <= imm_d;
                        ready_q    <= 1'b0;
                        state_q    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    rs_q    <= rs_val;
                    rt_q    <= rt_val;
                    state_q <= S_RESOLVE;
                end
                // Outputs are registered here so the new pc and done appear together in UPDATE.
                S_RESOLVE: begin
                    done_q  <= 1'b1;
                    state_q <= S_UPDATE;
                    if (err_d) begin
`ifdef PC_ALIGN_CHECK_EN
                        addr_err_q <= 1'b1;
`endif
                    end else begin
                        pc_q       <= taken_d ? target_d : pc_plus4_q;
                        br_taken_q <= taken_d;
                        link_we_q  <= link_d;
                        if (link_d) begin
                            link_addr_q <= pc_plus4_q;
                        end
                    end
                end
                S_UPDATE: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ready     = ready_q;
    assign pc        = pc_q;
    assign imm_ext   = imm_q;
    assign br_taken  = br_taken_q;
    assign link_we   = link_we_q;
    assign link_addr = link_addr_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl; all checks go through chk().
module tb_pc_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        ready;
    logic [31:0] pc;
    logic [31:0] imm_ext;
    logic        br_taken;
    logic        link_we;
    logic [31:0] link_addr;
    logic        done;
    logic        addr_err;

    int checks = 0;
    int errors = 0;

    pc_seq_ctrl #(.RESET_PC(32'h0040_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_valid(instr_valid),
        .instr      (instr),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .ready      (ready),
        .pc         (pc),
        .imm_ext    (imm_ext),
        .br_taken   (br_taken),
        .link_we    (link_we),
        .link_addr  (link_addr),
        .done       (done),
        .addr_err   (addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Called at a negedge while IDLE; returns at the negedge of the following IDLE cycle.
    task automatic run_instr(input string tag, input logic [31:0] ins, input logic [31:0] rs,
                             input logic [31:0] rt, input logic [31:0] imm_exp,
                             input logic [31:0] pc_exp, input logic br_exp, input logic lk_exp,
                             input logic [31:0] la_exp, input logic err_exp);
        int n = 0;
        instr       = ins;
        rs_val      = rs;
        rt_val      = rt;
        instr_valid = 1'b1;
        while (!ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " ready"}, {31'b0, ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = 32'hFFFF_FFFF;
        chk({tag, " imm_ext"}, imm_ext, imm_exp);
        chk({tag, " busy"}, {31'b0, ready}, 32'd0);
        @(negedge clk);
        rs_val = ~rs;
        rt_val = rt + 32'd1;
        chk({tag, " no early done"}, {31'b0, done}, 32'd0);
        @(negedge clk);
        chk({tag, " done"}, {31'b0, done}, 32'd1);
        chk({tag, " pc"}, pc, pc_exp);
        chk({tag, " br_taken"}, {31'b0, br_taken}, {31'b0, br_exp});
        chk({tag, " link_we"}, {31'b0, link_we}, {31'b0, lk_exp});
        if (lk_exp) chk({tag, " link_addr"}, link_addr, la_exp);
        chk({tag, " addr_err"}, {31'b0, addr_err}, {31'b0, err_exp});
        chk({tag, " imm hold"}, imm_ext, imm_exp);
        @(negedge clk);
        chk({tag, " done drop"}, {31'b0, done}, 32'd0);
        chk({tag, " idle ready"}, {31'b0, ready}, 32'd1);
        chk({tag, " pc hold"}, pc, pc_exp);
    endtask

    initial begin
        int done_cnt;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'h0;
        rs_val      = 32'h0;
        rt_val      = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst pc", pc, 32'h0040_0000);
        chk("rst ready", {31'b0, ready}, 32'd1);
        chk("rst done", {31'b0, done}, 32'd0);
        chk("rst imm", imm_ext, 32'h0);
        chk("rst link_addr", link_addr, 32'h0);
        chk("rst flags", {28'b0, br_taken, link_we, addr_err, done}, 32'h0);

        //          tag      instr          rs             rt             imm_ext        pc             br lk link_addr   err
        run_instr("add",    32'h0109_5020, 32'h1,         32'h2,         32'h0000_5020, 32'h0040_0004, 0, 0, 32'h0,         0);
        run_instr("j10a",   32'h0810_0004, 32'h0,         32'h0,         32'h0000_0004, 32'h0040_0010, 1, 0, 32'h0,         0);
        run_instr("beq_t",  32'h1085_FFFC, 32'd5,         32'd5,         32'hFFFF_FFFC, 32'h0040_0004, 1, 0, 32'h0,         0);
        run_instr("j10b",   32'h0810_0004, 32'h0,         32'h0,         32'h0000_0004, 32'h0040_0010, 1, 0, 32'h0,         0);
        run_instr("beq_n",  32'h1085_FFFC, 32'd5,         32'd6,         32'hFFFF_FFFC, 32'h0040_0014, 0, 0, 32'h0,         0);
        run_instr("j20",    32'h0810_0008, 32'h0,         32'h0,         32'h0000_0008, 32'h0040_0020, 1, 0, 32'h0,         0);
        run_instr("jal",    32'h0C10_0010, 32'h0,         32'h0,         32'h0000_0010, 32'h0040_0040, 1, 1, 32'h0040_0024, 0);
        run_instr("ori",    32'h3508_8000, 32'h0,         32'h0,         32'h0000_8000, 32'h0040_0044, 0, 0, 32'h0,         0);
        run_instr("addi",   32'h2108_8000, 32'h0,         32'h0,         32'hFFFF_8000, 32'h0040_0048, 0, 0, 32'h0,         0);

        // Reset in RESOLVE of a taken bne discards the instruction.
        instr       = 32'h1485_0004;
        rs_val      = 32'd1;
        rt_val      = 32'd2;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid pc", pc, 32'h0040_0000);
        chk("rstmid ready", {31'b0, ready}, 32'd1);
        chk("rstmid done", {31'b0, done}, 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("rstmid no done", done_cnt, 0);
        chk("rstmid pc hold", pc, 32'h0040_0000);

`ifdef PC_ALIGN_CHECK_EN
        run_instr("jr_mis", 32'h0080_0008, 32'h0040_0102, 32'h0,         32'h0000_0008, 32'h0040_0000, 0, 0, 32'h0,         1);
`else
        run_instr("jr_mis", 32'h0080_0008, 32'h0040_0102, 32'h0,         32'h0000_0008, 32'h0040_0102, 1, 0, 32'h0,         0);
`endif
        run_instr("jr_top", 32'h0080_0008, 32'hFFFF_FFFC, 32'h0,         32'h0000_0008, 32'hFFFF_FFFC, 1, 0, 32'h0,         0);
        run_instr("wrap",   32'h0109_5020, 32'h0,         32'h0,         32'h0000_5020, 32'h0000_0000, 0, 0, 32'h0,         0);
        run_instr("beq_wr", 32'h1085_FFFE, 32'd7,         32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFC, 1, 0, 32'h0,         0);
        run_instr("j_wr",   32'h0810_0004, 32'h0,         32'h0,         32'h0000_0004, 32'h0040_0010, 1, 0, 32'h0,         0);
        run_instr("bgez_t", 32'h0481_0002, 32'h7FFF_FFFF, 32'h0,         32'h0000_0002, 32'h0040_001C, 1, 0, 32'h0,         0);
        run_instr("bgez_n", 32'h0481_0002, 32'h8000_0000, 32'h0,         32'h0000_0002, 32'h0040_0020, 0, 0, 32'h0,         0);
        run_instr("jalr",   32'h0080_F809, 32'h0040_0200, 32'h0,         32'hFFFF_F809, 32'h0040_0200, 1, 1, 32'h0040_0024, 0);
        run_instr("bne_n",  32'h1485_0004, 32'd9,         32'd9,         32'h0000_0004, 32'h0040_0204, 0, 0, 32'h0,         0);

        // instr_valid held high: accept every 4th cycle.
        instr       = 32'h0109_5020;
        instr_valid = 1'b1;
        done_cnt    = 0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("tput ready %0d", i), {31'b0, ready}, (i % 4 == 0) ? 32'd1 : 32'd0);
            if (done) done_cnt++;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        chk("tput done count", done_cnt, 2);
        chk("tput pc", pc, 32'h0040_020C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
